psram_resp: RTL

PSRAM_RESP -- requirements
Module: psram_resp

---
 rtl/psram_resp.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/psram_resp.sv
// Octal-DDR PSRAM responder model: decodes read/write bursts from an
// oversampled SCK/CE/DQ bus and serves them from a small internal byte array.
module psram_resp #(
  parameter int         MEM_DEPTH = 256,
  parameter logic [7:0] RCMD      = 8'h00,
  parameter logic [7:0] WCMD      = 8'h80,
  parameter int         RLAT      = 5,
  parameter int         WLAT      = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_i,
  output logic [7:0] psram_io_o,
  output logic [7:0] psram_io_en_o,
  input  logic       psram_dqs_i,
  output logic       psram_dqs_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam int         AW      = $clog2(MEM_DEPTH);
  localparam logic [3:0] RLAT_V  = 4'(RLAT);
  localparam logic [3:0] WLAT_V  = 4'(WLAT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INST  = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_LATN  = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_SKIP  = 3'd6;

  // sync word layout {dqs, ce, sck, io[7:0]}; CE idles high out of reset
  localparam logic [10:0] SYNC_RST = 11'b010_0000_0000;

  logic [1:0][10:0] sync_pipe;
  logic [7:0]       io_s;
  logic             sck_s, ce_s, dqs_s, sck_d, ce_d;
  logic             sck_edge, sck_rise, ce_rise, ce_fall;

  logic [2:0]       state;
  logic [1:0]       cnt;
  logic [7:0]       inst_b;
  logic             is_rd;
  logic [31:0]      addr;
  logic [3:0]       lat_cnt;
  logic [3:0]       lat_nx;
  logic [AW-1:0]    ptr, ptr_nx;
  logic             io_en, mem_we;
  logic [7:0]       mem [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_pipe <= {SYNC_RST, SYNC_RST};
      sck_d     <= 1'b0;
      ce_d      <= 1'b1;
    end else begin
      sync_pipe <= {sync_pipe[0], {psram_dqs_i, psram_ce_i, psram_sck_i, psram_io_i}};
      sck_d     <= sck_s;
      ce_d      <= ce_s;
    end
  end

  assign io_s     = sync_pipe[1][7:0];
  assign sck_s    = sync_pipe[1][8];
  assign ce_s     = sync_pipe[1][9];
  assign dqs_s    = sync_pipe[1][10];
  assign sck_edge = sck_s ^ sck_d;
  assign sck_rise = sck_s & ~sck_d;
  assign ce_rise  = ce_s & ~ce_d;
  assign ce_fall  = ~ce_s & ce_d;

  assign ptr    = addr[AW-1:0];
  assign ptr_nx = ptr + 1'b1;
  assign lat_nx = lat_cnt + 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      inst_b      <= 8'h00;
      is_rd       <= 1'b0;
      addr        <= 32'd0;
      lat_cnt     <= 4'd0;
      io_en       <= 1'b0;
      psram_io_o  <= 8'h00;
      psram_dqs_o <= 1'b0;
      psram_dqs_en_o <= 1'b0;
      busy_o      <= 1'b0;
      cmd_err_o   <= 1'b0;
    end else begin
      cmd_err_o <= 1'b0;
      busy_o    <= (state != S_IDLE);
      // CE deassertion outranks any SCK edge seen in the same cycle
      if (state != S_IDLE && ce_rise) begin
        state          <= S_IDLE;
        io_en          <= 1'b0;
        psram_io_o     <= 8'h00;
        psram_dqs_o    <= 1'b0;
        psram_dqs_en_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (ce_fall) begin
            state <= S_INST;
            cnt   <= 2'd0;
          end
          S_INST: if (sck_edge) begin
            if (cnt == 2'd0) begin
              inst_b <= io_s;
              cnt    <= 2'd1;
            end else if (inst_b == io_s && (io_s == RCMD || io_s == WCMD)) begin
              is_rd <= (io_s == RCMD);
              cnt   <= 2'd0;
              state <= S_ADDR;
            end else begin
              cmd_err_o <= 1'b1;
              state     <= S_SKIP;
            end
          end
          S_ADDR: if (sck_edge) begin
            addr <= {addr[23:0], io_s};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              lat_cnt <= 4'd0;
              state   <= S_LATN;
            end
          end
          S_LATN: if (sck_rise) begin
            lat_cnt <= lat_nx;
            if (lat_nx == (is_rd ? RLAT_V : WLAT_V)) begin
              if (is_rd) begin
                state          <= S_RDATA;
                psram_io_o     <= mem[ptr];
                io_en          <= 1'b1;
                psram_dqs_en_o <= 1'b1;
                psram_dqs_o    <= 1'b1;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_WDATA: if (sck_edge) addr <= {addr[31:AW], ptr_nx};
          S_RDATA: if (sck_edge) begin
            addr        <= {addr[31:AW], ptr_nx};
            psram_io_o  <= mem[ptr_nx];
            psram_dqs_o <= ~psram_dqs_o;
          end
          default: ;
        endcase
      end
    end
  end

  assign psram_io_en_o = {8{io_en}};
  assign mem_we = !rst_i && state == S_WDATA && sck_edge && !ce_rise && !dqs_s;

  // storage keeps its contents across reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[ptr] <= io_s;
  end

endmodule
